// File: rtl/rf_sched_pkg.sv
// Shared widths and types for the register-file write scheduler.
package rf_sched_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NREGS  = 32;

   typedef logic [REG_W-1:0]  regsel_t;
   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Scoreboard of registers awaiting a long-latency write, with RAW hazard
// detection for decode and a sticky protocol-error flag.
module rf_scoreboard
   import rf_sched_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             mark_en,
   input  logic [REG_W-1:0] mark_sel,
   input  logic             clear_en,
   input  logic [REG_W-1:0] clear_sel,
   input  logic [REG_W-1:0] rsel1,
   input  logic [REG_W-1:0] rsel2,
   output logic [NREGS-1:0] busy,
   output logic             hazard1,
   output logic             hazard2,
   output logic             err
);

   logic [NREGS-1:0] busy_nxt;
   logic             err_set;

   // Next busy vector: clear first so a same-register mark wins.
   always_comb begin
      busy_nxt = busy;
      if (clear_en)
         busy_nxt[clear_sel] = 1'b0;
      if (mark_en && mark_sel != '0)
         busy_nxt[mark_sel] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Protocol violations: double mark without a clear, or a return nobody marked.
   always_comb begin
      err_set = 1'b0;
      if (mark_en && mark_sel != '0 && busy[mark_sel] &&
          !(clear_en && clear_sel == mark_sel))
         err_set = 1'b1;
      if (clear_en && !busy[clear_sel])
         err_set = 1'b1;
   end

   // Hazards bypass a return landing this cycle; the RF makes it readable in time.
   always_comb begin
      hazard1 = busy[rsel1] && !(clear_en && clear_sel == rsel1);
      hazard2 = busy[rsel2] && !(clear_en && clear_sel == rsel2);
   end

   // Scoreboard and sticky error state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (err_set)
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/rf_write_sched.sv
// Single write-port arbiter for the register file: pipeline writeback (A)
// normally wins, long-latency returns (B) win after MAX_WAIT refusals.
module rf_write_sched
   import rf_sched_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
)(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              a_valid,
   input  logic [REG_W-1:0]  a_wsel,
   input  logic [DATA_W-1:0] a_wdat,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [REG_W-1:0]  b_wsel,
   input  logic [DATA_W-1:0] b_wdat,
   output logic              b_ready,
   input  logic              mark_en,
   input  logic [REG_W-1:0]  mark_sel,
   input  logic [REG_W-1:0]  rsel1,
   input  logic [REG_W-1:0]  rsel2,
   output logic              hazard1,
   output logic              hazard2,
   output logic [NREGS-1:0]  busy,
   output logic              err,
   output logic              rf_wen,
   output logic [REG_W-1:0]  rf_wsel,
   output logic [DATA_W-1:0] rf_wdat
);

   logic [3:0] wait_cnt;
   logic       b_prio;
   logic       a_xfer;
   logic       b_xfer;

   // Arbitration; the two grants are mutually exclusive by construction.
   always_comb begin
      b_prio  = (wait_cnt == 4'(MAX_WAIT));
      a_ready = !(b_prio && b_valid);
      b_ready = !a_valid || b_prio;
      a_xfer  = a_valid && a_ready;
      b_xfer  = b_valid && b_ready;
   end

   // Write-port mux; r0 writes are accepted but never enabled.
   always_comb begin
      rf_wsel = '0;
      rf_wdat = '0;
      if (b_xfer) begin
         rf_wsel = b_wsel;
         rf_wdat = b_wdat;
      end else if (a_xfer) begin
         rf_wsel = a_wsel;
         rf_wdat = a_wdat;
      end
      rf_wen = (a_xfer || b_xfer) && rf_wsel != '0;
   end

   // Starvation counter: counts consecutive B refusals, saturating at MAX_WAIT.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         wait_cnt <= '0;
      else if (!b_valid || b_xfer)
         wait_cnt <= '0;
      else if (!b_prio)
         wait_cnt <= wait_cnt + 4'd1;
   end

   rf_scoreboard u_sb (
      .clk       (clk),
      .n_rst     (n_rst),
      .mark_en   (mark_en),
      .mark_sel  (mark_sel),
      .clear_en  (b_xfer),
      .clear_sel (b_wsel),
      .rsel1     (rsel1),
      .rsel2     (rsel2),
      .busy      (busy),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .err       (err)
   );

endmodule
